// File: rtl/inv_pkg.sv
// -----------------------------------------------------------------------------
// inv_pkg
// Shared definitions for the inventory state machine: the state encoding, the
// reply-type codes driven on tx_sel, and the bit positions of the one-hot
// command vector delivered by the packet parser.
// -----------------------------------------------------------------------------
package inv_pkg;

    typedef enum logic [2:0] {
        ST_READY     = 3'd0,
        ST_ARBITRATE = 3'd1,
        ST_REPLY     = 3'd2,
        ST_ACKED     = 3'd3
    } state_t;

    // Reply types selected for the transmitter
    localparam logic [2:0] TX_NONE   = 3'd0;
    localparam logic [2:0] TX_RN16   = 3'd1;
    localparam logic [2:0] TX_EPC    = 3'd2;
    localparam logic [2:0] TX_HANDLE = 3'd3;
    localparam logic [2:0] TX_DATA   = 3'd4;
    localparam logic [2:0] TX_SENSOR = 3'd5;

    // One-hot command vector bit positions
    localparam int CMD_W         = 13;
    localparam int CMD_QUERYREP  = 0;
    localparam int CMD_ACK       = 1;
    localparam int CMD_QUERY     = 2;
    localparam int CMD_QUERYADJ  = 3;
    localparam int CMD_SELECT    = 4;
    localparam int CMD_NACK      = 5;
    localparam int CMD_REQRN     = 6;
    localparam int CMD_READ      = 7;
    localparam int CMD_WRITE     = 8;
    localparam int CMD_SENSOR_LO = 9;
    localparam int CMD_SENSOR_HI = 12;

endpackage

// File: rtl/slot_counter.sv
// -----------------------------------------------------------------------------
// slot_counter
// Holds the anti-collision slot count. A load takes the random number masked
// to its low q_in bits; a decrement saturates at zero; set_ones parks the
// counter at all-ones. Look-ahead flags tell the FSM whether the value being
// loaded, or the result of a decrement, is zero.
//
// Ports
//   clk, reset  : clock, synchronous active-high reset (slot -> 0)
//   load        : load rng[SLOT_W-1:0] & low-q_in-bit mask (highest priority)
//   set_ones    : set slot to all-ones
//   dec         : decrement, saturating at zero
//   rng, q_in   : load source and mask width
//   slot        : current count
//   load_zero   : the value a load would store is zero
//   dec_zero    : the result of a decrement would be zero
// -----------------------------------------------------------------------------
module slot_counter #(
    parameter int SLOT_W = 15,
    parameter int Q_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              set_ones,
    input  logic              dec,
    input  logic [15:0]       rng,
    input  logic [Q_W-1:0]    q_in,
    output logic [SLOT_W-1:0] slot,
    output logic              load_zero,
    output logic              dec_zero
);

    logic [SLOT_W-1:0] mask;
    logic [SLOT_W-1:0] load_val;
    logic [SLOT_W-1:0] dec_val;

    // Mask of q_in ones from the LSB; q_in >= SLOT_W keeps every bit.
    always_comb begin
        mask = '0;
        for (int i = 0; i < SLOT_W; i++) begin
            mask[i] = (i < int'(q_in));
        end
    end

    assign load_val  = rng[SLOT_W-1:0] & mask;
    assign load_zero = (load_val == '0);
    assign dec_val   = (slot == '0) ? '0 : slot - SLOT_W'(1);
    assign dec_zero  = (dec_val == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= '0;
        end else if (load) begin
            slot <= load_val;
        end else if (set_ones) begin
            slot <= '1;
        end else if (dec) begin
            slot <= dec_val;
        end
    end

endmodule

// File: rtl/inventory_fsm.sv
// -----------------------------------------------------------------------------
// inventory_fsm
// Tag inventory state machine. Each rising edge of packet_complete is a packet
// event: the parser is always cleared, and if the CRCs are good and no reply
// is being transmitted, the decoded command moves the FSM and may start a
// reply (tx_start pulse with tx_sel).
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   cmd_in[12:0]     : one-hot command from parser (bit map in inv_pkg)
//   packet_complete  : level, high once a full packet is received
//   crc5invalid,
//   crc16invalid     : sticky CRC failure flags
//   q_in             : Q value of Query/QueryAdj
//   rng[15:0]        : free-running random number
//   tx_done          : one-cycle end-of-transmit pulse
//   state_out[2:0]   : current state
//   slot_out         : slot count
//   tx_start         : one-cycle transmit start pulse
//   tx_sel[2:0]      : reply type, held until the next transmit
//   tx_busy          : transmit in progress
//   parser_reset     : one-cycle parser clear request
//
// Build option
//   INV_SENSOR_CMDS_EN : when defined, sensor commands (cmd_in[12:9]) in
//                        ACKED reply with tx_sel = TX_SENSOR; otherwise they
//                        are treated as unknown commands.
// -----------------------------------------------------------------------------
module inventory_fsm
    import inv_pkg::*;
#(
    parameter int SLOT_W = 15,
    parameter int Q_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [12:0]       cmd_in,
    input  logic              packet_complete,
    input  logic              crc5invalid,
    input  logic              crc16invalid,
    input  logic [Q_W-1:0]    q_in,
    input  logic [15:0]       rng,
    input  logic              tx_done,
    output logic [2:0]        state_out,
    output logic [SLOT_W-1:0] slot_out,
    output logic              tx_start,
    output logic [2:0]        tx_sel,
    output logic              tx_busy,
    output logic              parser_reset
);

    state_t     state, state_nxt;
    logic       pc_q;
    logic       pkt_evt;
    logic       accept;
    logic       tx_go;
    logic [2:0] sel_nxt;
    logic       slot_load, slot_ones, slot_dec;
    logic       load_zero, dec_zero;

    assign pkt_evt = packet_complete & ~pc_q;

    // A tx_done in the same cycle as the event frees the transmitter first.
    // The tx_start cycle counts as busy, since tx_busy only rises after it.
    assign accept = pkt_evt & ~crc5invalid & ~crc16invalid
                  & ~tx_start & ~(tx_busy & ~tx_done);

    slot_counter #(
        .SLOT_W (SLOT_W),
        .Q_W    (Q_W)
    ) u_slot_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (slot_load),
        .set_ones  (slot_ones),
        .dec       (slot_dec),
        .rng       (rng),
        .q_in      (q_in),
        .slot      (slot_out),
        .load_zero (load_zero),
        .dec_zero  (dec_zero)
    );

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_READY;
            pc_q         <= 1'b0;
            tx_start     <= 1'b0;
            tx_sel       <= TX_NONE;
            tx_busy      <= 1'b0;
            parser_reset <= 1'b1;
        end else begin
            state        <= state_nxt;
            pc_q         <= packet_complete;
            tx_start     <= tx_go;
            parser_reset <= pkt_evt;
            if (tx_go) begin
                tx_sel <= sel_nxt;
            end
            if (tx_start) begin
                tx_busy <= 1'b1;
            end else if (tx_busy && tx_done) begin
                tx_busy <= 1'b0;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        tx_go     = 1'b0;
        sel_nxt   = TX_NONE;
        slot_load = 1'b0;
        slot_ones = 1'b0;
        slot_dec  = 1'b0;

        if (accept) begin
            if (cmd_in[CMD_NACK] || cmd_in[CMD_SELECT]) begin
                state_nxt = ST_READY;
            end else if (cmd_in[CMD_QUERY] || cmd_in[CMD_QUERYADJ]) begin
                slot_load = 1'b1;
                if (load_zero) begin
                    state_nxt = ST_REPLY;
                    tx_go     = 1'b1;
                    sel_nxt   = TX_RN16;
                end else begin
                    state_nxt = ST_ARBITRATE;
                end
            end else if (cmd_in[CMD_QUERYREP]) begin
                case (state)
                    ST_ARBITRATE: begin
                        slot_dec = 1'b1;
                        if (dec_zero) begin
                            state_nxt = ST_REPLY;
                            tx_go     = 1'b1;
                            sel_nxt   = TX_RN16;
                        end
                    end
                    ST_REPLY: begin
                        slot_ones = 1'b1;
                        state_nxt = ST_ARBITRATE;
                    end
                    ST_ACKED: state_nxt = ST_READY;
                    default:  ;
                endcase
            end else if (cmd_in[CMD_ACK]) begin
                if (state == ST_REPLY || state == ST_ACKED) begin
                    state_nxt = ST_ACKED;
                    tx_go     = 1'b1;
                    sel_nxt   = TX_EPC;
                end
            end else if (state == ST_ACKED) begin
                if (cmd_in[CMD_REQRN]) begin
                    tx_go   = 1'b1;
                    sel_nxt = TX_HANDLE;
                end else if (cmd_in[CMD_READ] || cmd_in[CMD_WRITE]) begin
                    tx_go   = 1'b1;
                    sel_nxt = TX_DATA;
                end
`ifdef INV_SENSOR_CMDS_EN
                else if (|cmd_in[CMD_SENSOR_HI:CMD_SENSOR_LO]) begin
                    tx_go   = 1'b1;
                    sel_nxt = TX_SENSOR;
                end
`endif
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_inventory_fsm.sv
// -----------------------------------------------------------------------------
// tb_inventory_fsm
// Self-checking bench for inventory_fsm. Expected reply types are queued when
// a packet is driven and compared as each tx_start pulse appears; state, slot,
// busy and parser_reset are checked directly against hand-derived values.
// -----------------------------------------------------------------------------
module tb_inventory_fsm;
    import inv_pkg::*;

    localparam int SLOT_W = 15;
    localparam int Q_W    = 4;

    logic              clk;
    logic              reset;
    logic [12:0]       cmd_in;
    logic              packet_complete;
    logic              crc5invalid;
    logic              crc16invalid;
    logic [Q_W-1:0]    q_in;
    logic [15:0]       rng;
    logic              tx_done;
    logic [2:0]        state_out;
    logic [SLOT_W-1:0] slot_out;
    logic              tx_start;
    logic [2:0]        tx_sel;
    logic              tx_busy;
    logic              parser_reset;

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] sb[$];

    inventory_fsm #(
        .SLOT_W (SLOT_W),
        .Q_W    (Q_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_in          (cmd_in),
        .packet_complete (packet_complete),
        .crc5invalid     (crc5invalid),
        .crc16invalid    (crc16invalid),
        .q_in            (q_in),
        .rng             (rng),
        .tx_done         (tx_done),
        .state_out       (state_out),
        .slot_out        (slot_out),
        .tx_start        (tx_start),
        .tx_sel          (tx_sel),
        .tx_busy         (tx_busy),
        .parser_reset    (parser_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every tx_start must match the oldest queued reply type.
    always @(negedge clk) begin
        if (tx_start) begin
            if (sb.size() == 0) begin
                check("unexpected_tx_start", 32'(tx_start), 32'd0);
            end else begin
                check("tx_sel", 32'(tx_sel), 32'(sb.pop_front()));
            end
        end
    end

    // Drive one packet (bit_idx < 0 means no command bit). Called at a negedge.
    task automatic send(input int bit_idx, input logic [Q_W-1:0] q, input logic [15:0] r,
                        input logic bad5, input logic expect_tx, input logic [2:0] sel);
        logic [12:0] one;
        one = 13'd1;
        if (expect_tx) sb.push_back(sel);
        cmd_in          = (bit_idx < 0) ? 13'd0 : (one << bit_idx);
        q_in            = q;
        rng             = r;
        crc5invalid     = bad5;
        packet_complete = 1'b1;
        @(negedge clk);
        check("parser_reset_pulse", 32'(parser_reset), 32'd1);
        packet_complete = 1'b0;
        crc5invalid     = 1'b0;
        cmd_in          = '0;
        @(negedge clk);
        check("parser_reset_end", 32'(parser_reset), 32'd0);
    endtask

    task automatic expect_state(input string tag, input state_t st, input logic [SLOT_W-1:0] sl);
        check({tag, "_state"}, 32'(state_out), 32'(st));
        check({tag, "_slot"}, 32'(slot_out), 32'(sl));
    endtask

    task automatic finish_tx(input string tag);
        check({tag, "_busy_before_done"}, 32'(tx_busy), 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({tag, "_busy_after_done"}, 32'(tx_busy), 32'd0);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        cmd_in          = '0;
        packet_complete = 1'b0;
        crc5invalid     = 1'b0;
        crc16invalid    = 1'b0;
        q_in            = '0;
        rng             = '0;
        tx_done         = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        expect_state("reset", ST_READY, '0);
        check("reset_tx_start", 32'(tx_start), 32'd0);
        check("reset_tx_sel", 32'(tx_sel), 32'd0);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);
        check("reset_parser_reset", 32'(parser_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_parser_reset", 32'(parser_reset), 32'd0);

        // tx_done while idle is ignored
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("idle_tx_done_busy", 32'(tx_busy), 32'd0);

        // Query q=0 -> immediate reply
        send(CMD_QUERY, 4'd0, 16'hBEEF, 1'b0, 1'b1, TX_RN16);
        expect_state("q0", ST_REPLY, '0);
        finish_tx("q0");

        // QueryRep in REPLY -> ARBITRATE with slot all-ones
        send(CMD_QUERYREP, 4'd0, 16'h0, 1'b0, 1'b0, TX_NONE);
        expect_state("rep_from_reply", ST_ARBITRATE, 15'h7FFF);

        // Mask boundaries
        send(CMD_QUERYADJ, 4'd15, 16'hFFFF, 1'b0, 1'b0, TX_NONE);
        expect_state("q15", ST_ARBITRATE, 15'h7FFF);
        send(CMD_QUERY, 4'd4, 16'h1235, 1'b0, 1'b0, TX_NONE);
        expect_state("q4", ST_ARBITRATE, 15'd5);

        // Query q=2 rng=3 -> slot 3, three QueryReps reach REPLY
        send(CMD_QUERY, 4'd2, 16'h0003, 1'b0, 1'b0, TX_NONE);
        expect_state("q2", ST_ARBITRATE, 15'd3);
        send(CMD_QUERYREP, 4'd0, 16'h0, 1'b0, 1'b0, TX_NONE);
        expect_state("rep1", ST_ARBITRATE, 15'd2);
        send(CMD_QUERYREP, 4'd0, 16'h0, 1'b0, 1'b0, TX_NONE);
        expect_state("rep2", ST_ARBITRATE, 15'd1);
        send(CMD_QUERYREP, 4'd0, 16'h0, 1'b0, 1'b1, TX_RN16);
        expect_state("rep3", ST_REPLY, 15'd0);
        finish_tx("rep3");

        // Ack -> ACKED/EPC, Read -> data, QueryRep -> READY
        send(CMD_ACK, 4'd0, 16'h0, 1'b0, 1'b1, TX_EPC);
        check("ack_state", 32'(state_out), 32'(ST_ACKED));
        finish_tx("ack");
        send(CMD_READ, 4'd0, 16'h0, 1'b0, 1'b1, TX_DATA);
        check("read_state", 32'(state_out), 32'(ST_ACKED));
        finish_tx("read");
        send(CMD_QUERYREP, 4'd0, 16'h0, 1'b0, 1'b0, TX_NONE);
        check("acked_rep_state", 32'(state_out), 32'(ST_READY));

        // Bad CRC: discarded, parser_reset still pulses
        send(CMD_QUERY, 4'd0, 16'h1234, 1'b1, 1'b0, TX_NONE);
        check("crc5_state", 32'(state_out), 32'(ST_READY));
        check("crc5_busy", 32'(tx_busy), 32'd0);

        // Ack while busy is ignored; tx_done coincident with Nack
        send(CMD_QUERY, 4'd0, 16'h0, 1'b0, 1'b1, TX_RN16);
        send(CMD_ACK, 4'd0, 16'h0, 1'b0, 1'b0, TX_NONE);
        check("busy_ack_state", 32'(state_out), 32'(ST_REPLY));
        check("busy_ack_busy", 32'(tx_busy), 32'd1);
        tx_done         = 1'b1;
        cmd_in          = 13'd1 << CMD_NACK;
        packet_complete = 1'b1;
        @(negedge clk);
        tx_done         = 1'b0;
        packet_complete = 1'b0;
        cmd_in          = '0;
        check("coinc_busy", 32'(tx_busy), 32'd0);
        check("coinc_state", 32'(state_out), 32'(ST_READY));
        check("coinc_parser_reset", 32'(parser_reset), 32'd1);
        @(negedge clk);

        // Sensor command in ACKED
        send(CMD_QUERY, 4'd0, 16'h0, 1'b0, 1'b1, TX_RN16);
        finish_tx("s_q");
        send(CMD_ACK, 4'd0, 16'h0, 1'b0, 1'b1, TX_EPC);
        finish_tx("s_ack");
`ifdef INV_SENSOR_CMDS_EN
        send(10, 4'd0, 16'h0, 1'b0, 1'b1, TX_SENSOR);
        check("sensor_state", 32'(state_out), 32'(ST_ACKED));
        finish_tx("sensor");
`else
        send(10, 4'd0, 16'h0, 1'b0, 1'b0, TX_NONE);
        check("sensor_state", 32'(state_out), 32'(ST_ACKED));
        check("sensor_no_busy", 32'(tx_busy), 32'd0);
        check("sensor_tx_sel_held", 32'(tx_sel), 32'(TX_EPC));
`endif

        // Reset mid-transmit: abandoned, no later tx_start
        send(CMD_REQRN, 4'd0, 16'h0, 1'b0, 1'b1, TX_HANDLE);
        check("mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_busy", 32'(tx_busy), 32'd0);
        check("mid_reset_state", 32'(state_out), 32'(ST_READY));
        check("mid_reset_tx_sel", 32'(tx_sel), 32'd0);
        check("mid_reset_parser_reset", 32'(parser_reset), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_mid_busy", 32'(tx_busy), 32'd0);
        check("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
